// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART command-frame parser.
package uart_frame_pkg;

    localparam logic [7:0] SOF0 = 8'h55;
    localparam logic [7:0] SOF1 = 8'hAA;

    localparam int DEF_MAX_LEN     = 16;
    localparam int DEF_TIMEOUT_CYC = 50000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF1,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

endpackage

// File: rtl/frame_payload_buf.sv
// Payload RAM: one write port, registered read port with a 1-cycle latency.
module frame_payload_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frames 0x55 0xAA CMD LEN PAYLOAD[LEN] CSUM out of the UART byte stream.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | hunting for first sync byte 0x55
// ST_SOF1    | 0x55 seen, expecting 0xAA (repeated 0x55 tolerated)
// ST_CMD     | next byte is the command
// ST_LEN     | next byte is the payload length
// ST_PAYLOAD | collecting payload bytes into the buffer
// ST_CSUM    | next byte is the checksum
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [7:0]                   data_byte,
    input  logic                         rx_done,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    output logic [7:0]                   cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic                         frame_valid,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(TIMEOUT_CYC);

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      cmd_sh;
    logic [LW-1:0]   len_sh;
    logic [7:0]      sum;
    logic [AW-1:0]   idx;
    logic [CW-1:0]   tmo_cnt;

    logic            timeout;
    logic            len_too_long;
    logic            last_byte;
    logic            csum_ok;
    logic            fv_nxt;
    logic            fe_nxt;
    logic            buf_we;

    // A byte arriving on the terminal cycle takes priority over the timeout.
    assign timeout      = (state != ST_IDLE) && (tmo_cnt == CW'(TIMEOUT_CYC - 1)) && !rx_done;
    assign len_too_long = data_byte > 8'(MAX_LEN);
    assign last_byte    = (LW'(idx) + LW'(1)) == len_sh;
    assign csum_ok      = data_byte == sum;
    assign busy         = state != ST_IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rx_done) begin
            case (state)
                ST_IDLE: begin
                    if (data_byte == SOF0) state_nxt = ST_SOF1;
                end
                ST_SOF1: begin
                    if (data_byte == SOF1)      state_nxt = ST_CMD;
                    else if (data_byte != SOF0) state_nxt = ST_IDLE;
                end
                ST_CMD: state_nxt = ST_LEN;
                ST_LEN: begin
                    if (len_too_long)         state_nxt = ST_IDLE;
                    else if (data_byte == 0)  state_nxt = ST_CSUM;
                    else                      state_nxt = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (last_byte) state_nxt = ST_CSUM;
                end
                ST_CSUM: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        fv_nxt = 1'b0;
        fe_nxt = 1'b0;
        buf_we = 1'b0;
        if (rx_done) begin
            case (state)
                ST_LEN:     fe_nxt = len_too_long;
                ST_PAYLOAD: buf_we = 1'b1;
                ST_CSUM: begin
                    fv_nxt = csum_ok;
                    fe_nxt = !csum_ok;
                end
                default: ;
            endcase
        end else if (timeout) begin
            fe_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            cmd         <= 8'h00;
            len         <= '0;
            cmd_sh      <= 8'h00;
            len_sh      <= '0;
            sum         <= 8'h00;
            idx         <= '0;
            tmo_cnt     <= '0;
        end else begin
            frame_valid <= fv_nxt;
            frame_err   <= fe_nxt;

            if (state == ST_IDLE || rx_done || timeout) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (rx_done) begin
                case (state)
                    ST_CMD: begin
                        cmd_sh <= data_byte;
                        sum    <= data_byte;
                    end
                    ST_LEN: begin
                        if (!len_too_long) begin
                            len_sh <= LW'(data_byte);
                            sum    <= sum + data_byte;
                            idx    <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        sum <= sum + data_byte;
                        idx <= idx + 1'b1;
                    end
                    ST_CSUM: begin
                        if (csum_ok) begin
                            cmd <= cmd_sh;
                            len <= len_sh;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    frame_payload_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (buf_we),
        .waddr   (idx),
        .wdata   (data_byte),
        .raddr   (rd_addr),
        .rdata   (rd_data)
    );

endmodule
